// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher: channel state encoding
// and the down-counter width calculation.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } ps_state_t;

  // Counter must hold the larger of the two reload values (n-1), so size for max+1.
  function automatic int unsigned cnt_width(input int unsigned stretch_cycles,
                                            input int unsigned holdoff_cycles);
    int unsigned m;
    m = (stretch_cycles > holdoff_cycles) ? stretch_cycles : holdoff_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_channel.sv
// One pulse stretcher channel: IDLE/ACTIVE/HOLDOFF FSM, down-counter,
// one-deep pending flag and registered drop indication.
module pulse_stretcher_channel
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned stretch_cycles = 4,
  parameter int unsigned holdoff_cycles = 2,
  parameter bit          retrigger      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic level_out,
  output logic busy,
  output logic dropped
);

  localparam int unsigned     CW           = cnt_width(stretch_cycles, holdoff_cycles);
  localparam logic [CW-1:0]   STRETCH_LOAD = CW'(stretch_cycles - 1);
  localparam logic [CW-1:0]   HOLD_LOAD    = CW'(holdoff_cycles - 1);
  localparam logic [CW-1:0]   CNT_ONE      = CW'(1);

  ps_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pend, pend_n;
  logic          drop_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend    <= pend_n;
      dropped <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    drop_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pulse_in) begin
          state_n = ACTIVE;
          cnt_n   = STRETCH_LOAD;
        end
      end
      ACTIVE: begin
        if (retrigger && pulse_in) begin
          cnt_n = STRETCH_LOAD;
        end else if (cnt == '0) begin
          state_n = HOLDOFF;
          cnt_n   = HOLD_LOAD;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
        if (!retrigger && pulse_in) begin
          if (pend) drop_n = 1'b1;
          else      pend_n = 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_ONE;
          if (pulse_in) begin
            if (pend) drop_n = 1'b1;
            else      pend_n = 1'b1;
          end
        end else if (pend || pulse_in) begin
          // A same-edge pulse re-queues when the pending one is consumed here.
          state_n = ACTIVE;
          cnt_n   = STRETCH_LOAD;
          pend_n  = pend & pulse_in;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        pend_n  = 1'b0;
      end
    endcase
  end

  assign level_out = (state == ACTIVE);
  assign busy      = (state != IDLE) || pend;

endmodule

// File: rtl/pulse_stretcher.sv
// Multi-channel pulse stretcher: turns single-cycle strobes into level windows
// with guaranteed high time and low holdoff, one independent channel per bit.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned width          = 1,
  parameter int unsigned stretch_cycles = 4,
  parameter int unsigned holdoff_cycles = 2,
  parameter bit          retrigger      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] pulse_in,
  output logic [width-1:0] level_out,
  output logic [width-1:0] busy,
  output logic [width-1:0] dropped
);

  if (stretch_cycles == 0) begin : g_bad_stretch
    $error("pulse_stretcher: stretch_cycles must be >= 1");
  end
  if (holdoff_cycles == 0) begin : g_bad_holdoff
    $error("pulse_stretcher: holdoff_cycles must be >= 1");
  end

  for (genvar i = 0; i < int'(width); i++) begin : g_ch
    pulse_stretcher_channel #(
      .stretch_cycles(stretch_cycles),
      .holdoff_cycles(holdoff_cycles),
      .retrigger     (retrigger)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .pulse_in (pulse_in[i]),
      .level_out(level_out[i]),
      .busy     (busy[i]),
      .dropped  (dropped[i])
    );
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: four configurations side by side,
// checked every cycle against a window-deadline model plus literal expectations.
module tb_pulse_stretcher;

  localparam int NCH = 9;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] p_all;
  wire  [NCH-1:0] lvl_all, busy_all, drop_all;

  int errors = 0;
  int checks = 0;
  int tcnt   = 0;

  // Model: per channel, the edge at which the current window falls and the
  // edge at which the holdoff expires, plus the one-deep queue.
  int fall_t  [NCH];
  int ready_t [NCH];
  bit pend_m  [NCH];
  bit drop_m  [NCH];

  // ch0-2: retrigger, 4/2 ; ch3-5: queued, 4/2 ; ch6-7: queued, 1/1 ; ch8: defaults
  pulse_stretcher #(.width(3), .stretch_cycles(4), .holdoff_cycles(2), .retrigger(1'b1)) dut_r (
    .clk(clk), .rst(rst), .pulse_in(p_all[2:0]),
    .level_out(lvl_all[2:0]), .busy(busy_all[2:0]), .dropped(drop_all[2:0]));
  pulse_stretcher #(.width(3), .stretch_cycles(4), .holdoff_cycles(2), .retrigger(1'b0)) dut_q (
    .clk(clk), .rst(rst), .pulse_in(p_all[5:3]),
    .level_out(lvl_all[5:3]), .busy(busy_all[5:3]), .dropped(drop_all[5:3]));
  pulse_stretcher #(.width(2), .stretch_cycles(1), .holdoff_cycles(1), .retrigger(1'b0)) dut_s (
    .clk(clk), .rst(rst), .pulse_in(p_all[7:6]),
    .level_out(lvl_all[7:6]), .busy(busy_all[7:6]), .dropped(drop_all[7:6]));
  pulse_stretcher dut_d (
    .clk(clk), .rst(rst), .pulse_in(p_all[8:8]),
    .level_out(lvl_all[8:8]), .busy(busy_all[8:8]), .dropped(drop_all[8:8]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int s_of(input int ch);
    return (ch == 6 || ch == 7) ? 1 : 4;
  endfunction
  function automatic int h_of(input int ch);
    return (ch == 6 || ch == 7) ? 1 : 2;
  endfunction
  function automatic bit rt_of(input int ch);
    return (ch <= 2 || ch == 8);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      fall_t[c]  = -1000;
      ready_t[c] = -1000;
      pend_m[c]  = 1'b0;
      drop_m[c]  = 1'b0;
    end
  endfunction

  function automatic void queue_pulse(input int c);
    if (pend_m[c]) drop_m[c] = 1'b1;
    else           pend_m[c] = 1'b1;
  endfunction

  function automatic void model_edge(input logic [NCH-1:0] p);
    int t;
    t = tcnt;
    for (int c = 0; c < NCH; c++) begin
      drop_m[c] = 1'b0;
      if (t <= fall_t[c]) begin
        if (p[c] && rt_of(c)) fall_t[c] = t + s_of(c);
        else if (p[c])        queue_pulse(c);
        ready_t[c] = fall_t[c] + h_of(c);
      end else if (t < ready_t[c]) begin
        if (p[c]) queue_pulse(c);
      end else if ((t == ready_t[c] && pend_m[c]) || p[c]) begin
        fall_t[c]  = t + s_of(c);
        ready_t[c] = fall_t[c] + h_of(c);
        pend_m[c]  = pend_m[c] & p[c];
      end
    end
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %b expected %b", name, tcnt, act, exp);
    end
  endtask

  task automatic vchk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %b expected %b", name, tcnt, act, exp);
    end
  endtask

  task automatic step(input logic [NCH-1:0] pv);
    logic [NCH-1:0] el, eb, ed;
    p_all = pv;
    @(posedge clk);
    tcnt++;
    model_edge(pv);
    #1;
    for (int c = 0; c < NCH; c++) begin
      el[c] = (tcnt < fall_t[c]);
      eb[c] = (tcnt < ready_t[c]) || pend_m[c];
      ed[c] = drop_m[c];
    end
    vchk("level_out", lvl_all, el);
    vchk("busy", busy_all, eb);
    vchk("dropped", drop_all, ed);
  endtask

  // Called right after step(): asserts reset between edges and checks outputs
  // clear with no clock edge involved.
  task automatic async_reset_mid();
    #3 rst = 1'b1;
    #1;
    vchk("async rst level_out", lvl_all, '0);
    vchk("async rst busy", busy_all, '0);
    vchk("async rst dropped", drop_all, '0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [NCH-1:0] pv;
    int unsigned    dens;

    rst   = 1'b1;
    p_all = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vchk("reset level_out", lvl_all, '0);
    vchk("reset busy", busy_all, '0);
    vchk("reset dropped", drop_all, '0);
    rst = 1'b0;

    // Single pulse, retrigger extension, queued second window and a discard.
    for (int k = 0; k < 14; k++) begin
      pv = '0;
      if (k == 0) pv = 9'b1_0001_1011;
      if (k == 1) pv = 9'b0_0001_0000;
      if (k == 2) pv = 9'b0_0001_1010;
      step(pv);
      case (k)
        0: begin
          chk("single rise ch0", lvl_all[0], 1'b1);
          chk("single rise dflt", lvl_all[8], 1'b1);
          chk("single busy ch0", busy_all[0], 1'b1);
        end
        1: chk("no drop on first queue", drop_all[4], 1'b0);
        2: chk("drop after 3rd pulse", drop_all[4], 1'b1);
        3: begin
          chk("single last high ch0", lvl_all[0], 1'b1);
          chk("drop one cycle", drop_all[4], 1'b0);
        end
        4: begin
          chk("single fall ch0", lvl_all[0], 1'b0);
          chk("single holdoff busy ch0", busy_all[0], 1'b1);
          chk("retrig still high ch1", lvl_all[1], 1'b1);
          chk("queued gap low ch3", lvl_all[3], 1'b0);
          chk("queued gap busy ch3", busy_all[3], 1'b1);
        end
        5: begin
          chk("retrig still high ch1 e5", lvl_all[1], 1'b1);
          chk("queued gap low ch3 e5", lvl_all[3], 1'b0);
          chk("queued gap busy ch3 e5", busy_all[3], 1'b1);
        end
        6: begin
          chk("single idle ch0", busy_all[0], 1'b0);
          chk("single idle dflt", busy_all[8], 1'b0);
          chk("retrig fall ch1", lvl_all[1], 1'b0);
          chk("second window ch3", lvl_all[3], 1'b1);
          chk("second window ch4", lvl_all[4], 1'b1);
        end
        9:  chk("second window last ch3", lvl_all[3], 1'b1);
        10: begin
          chk("second window fall ch3", lvl_all[3], 1'b0);
          chk("second window fall ch4", lvl_all[4], 1'b0);
        end
        11: chk("final holdoff busy ch3", busy_all[3], 1'b1);
        12: chk("final idle ch3", busy_all[3], 1'b0);
        default: ;
      endcase
    end

    // Mid-window asynchronous reset, including a queued pulse on ch3.
    step(9'b1_0000_1001);
    step(9'b0_0000_1000);
    async_reset_mid();
    repeat (3) step('0);
    chk("queued pulse lost ch3", lvl_all[3], 1'b0);
    for (int k = 0; k < 8; k++) begin
      step((k == 0) ? 9'b0_0000_0001 : 9'b0_0000_0000);
      case (k)
        0: chk("post-rst rise ch0", lvl_all[0], 1'b1);
        3: chk("post-rst high ch0", lvl_all[0], 1'b1);
        4: chk("post-rst fall ch0", lvl_all[0], 1'b0);
        5: chk("post-rst holdoff ch0", busy_all[0], 1'b1);
        6: chk("post-rst idle ch0", busy_all[0], 1'b0);
        default: ;
      endcase
    end

    // Independent channels; pulses on the cnt==0 edge (retrigger and queued).
    for (int k = 0; k < 14; k++) begin
      pv = '0;
      if (k == 0) pv = 9'b1_0010_0101;
      if (k == 1) pv = 9'b0_0000_0110;
      if (k == 3) pv = 9'b1_0010_0000;
      step(pv);
      case (k)
        3: chk("indep high ch0", lvl_all[0], 1'b1);
        4: begin
          chk("indep fall ch0", lvl_all[0], 1'b0);
          chk("indep high ch1", lvl_all[1], 1'b1);
          chk("5-cycle high ch2", lvl_all[2], 1'b1);
          chk("cnt0 queue gap ch5", lvl_all[5], 1'b0);
        end
        5: begin
          chk("indep fall ch1", lvl_all[1], 1'b0);
          chk("5-cycle fall ch2", lvl_all[2], 1'b0);
          chk("indep holdoff ch0", busy_all[0], 1'b1);
        end
        6: begin
          chk("indep idle ch0", busy_all[0], 1'b0);
          chk("indep holdoff ch2", busy_all[2], 1'b1);
          chk("cnt0 retrig high dflt", lvl_all[8], 1'b1);
          chk("cnt0 queued window ch5", lvl_all[5], 1'b1);
        end
        7: begin
          chk("indep idle ch1", busy_all[1], 1'b0);
          chk("indep idle ch2", busy_all[2], 1'b0);
          chk("cnt0 retrig fall dflt", lvl_all[8], 1'b0);
        end
        default: ;
      endcase
    end

    // Randomized traffic with varying density and occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      dens = (n / 500) % 3;
      for (int c = 0; c < NCH; c++)
        pv[c] = ($urandom_range(0, (2 << dens) - 1) == 0);
      step(pv);
      if ($urandom_range(0, 399) == 0) async_reset_mid();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
